// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer-then-data protocol, no clock stretching.
// Define I2C_TARGET_GENCALL_EN to ACK general call and honour the 8'h06 register-clear command.
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDR = 7'h3C,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned PTR_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_addr,
  output logic                  busy
);

`ifdef I2C_TARGET_GENCALL_EN
  localparam bit GenCallEn = 1'b1;
`else
  localparam bit GenCallEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdMack, StWaitStop
  } state_e;

  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_d_q, sda_d_q;
  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       sr_q;
  logic [PTR_W-1:0] ptr_q;
  logic             gc_q;
  logic [7:0]       regs_q [NUM_REGS];

  // Sync flops idle high so leaving reset never looks like a bus edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_d_q    <= scl_sync_q[1];
      sda_d_q    <= sda_sync_q[1];
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_d_q;
  assign scl_fall  = ~scl & scl_d_q;
  assign start_det = scl & sda_d_q & ~sda;
  assign stop_det  = scl & ~sda_d_q & sda;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      ptr_q     <= '0;
      gc_q      <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state_q <= StAddr;
        cnt_q   <= 4'd0;
        sda_oe  <= 1'b0;
        gc_q    <= 1'b0;
      end else if (stop_det) begin
        state_q <= StIdle;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              if (sr_q[7:1] == TARGET_ADDR) begin
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                state_q <= StAddrAck;
              end else if (GenCallEn && sr_q == 8'h00) begin
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
                gc_q    <= 1'b1;
                state_q <= StAddrAck;
              end else begin
                busy    <= 1'b0;
                state_q <= StWaitStop;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (sr_q[0]) begin
                sr_q    <= regs_q[ptr_q];
                sda_oe  <= ~regs_q[ptr_q][7];
                state_q <= StRdata;
              end else begin
                sda_oe  <= 1'b0;
                state_q <= StPtr;
              end
            end
          end
          StPtr: begin
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              if (gc_q) begin
                sda_oe  <= 1'b1;
                state_q <= StPtrAck;
                if (sr_q == 8'h06) begin
                  ptr_q <= '0;
                  for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
                end
              end else if ({24'h0, sr_q} < NUM_REGS) begin
                ptr_q   <= sr_q[PTR_W-1:0];
                sda_oe  <= 1'b1;
                state_q <= StPtrAck;
              end else begin
                state_q <= StWaitStop;
              end
            end
          end
          StPtrAck: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              cnt_q   <= 4'd0;
              state_q <= gc_q ? StWaitStop : StWdata;
            end
          end
          StWdata: begin
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q         <= 4'd0;
              regs_q[ptr_q] <= sr_q;
              wr_strobe     <= 1'b1;
              wr_addr       <= ptr_q;
              sda_oe        <= 1'b1;
              state_q       <= StWdataAck;
            end
          end
          StWdataAck: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              ptr_q   <= ptr_q + PTR_W'(1);
              cnt_q   <= 4'd0;
              state_q <= StWdata;
            end
          end
          StRdata: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                // Byte fully sent: release for the master's ACK and move past it.
                sda_oe  <= 1'b0;
                ptr_q   <= ptr_q + PTR_W'(1);
                cnt_q   <= 4'd0;
                state_q <= StRdMack;
              end else begin
                sda_oe <= ~sr_q[6];
                sr_q   <= {sr_q[6:0], 1'b0};
              end
            end
          end
          StRdMack: begin
            if (scl_rise) begin
              cnt_q <= 4'd1;
              if (sda) state_q <= StWaitStop;
            end else if (scl_fall && cnt_q == 4'd1) begin
              cnt_q   <= 4'd0;
              sr_q    <= regs_q[ptr_q];
              sda_oe  <= ~regs_q[ptr_q][7];
              state_q <= StRdata;
            end
          end
          StWaitStop: sda_oe <= 1'b0;
          StIdle:     sda_oe <= 1'b0;
          default:    state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs_q[g];
  end

endmodule
